// File: rtl/tiled_sprite_anim.sv
// tiled_sprite_anim: animated tiled background source with scroll, mirroring and a two-stage lookup
module tiled_sprite_anim #(
  parameter int X_OFFSET    = 0,
  parameter int Y_OFFSET    = 0,
  parameter int CANVAS_W    = 160,
  parameter int CANVAS_H    = 120,
  parameter int TW_LOG2     = 3,
  parameter int TH_LOG2     = 3,
  parameter int FR_LOG2     = 2,
  parameter int PAL_W       = 4,
  parameter int TRANSPARENT = 15,
  parameter int ANIM_PERIOD = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [9:0]                           x,
  input  logic [9:0]                           y,
  input  logic                                 frame_start,
  input  logic [TW_LOG2-1:0]                   scroll_x,
  input  logic [TH_LOG2-1:0]                   scroll_y,
  input  logic                                 mirror_x,
  input  logic                                 mirror_y,
  input  logic                                 anim_en,
  input  logic                                 wr_en,
  input  logic [FR_LOG2+TH_LOG2+TW_LOG2-1:0]   wr_addr,
  input  logic [PAL_W-1:0]                     wr_data,
  output logic [FR_LOG2-1:0]                   cur_frame,
  output logic [PAL_W-1:0]                     paletteIndex,
  output logic                                 valid
);
  localparam int AW = FR_LOG2 + TH_LOG2 + TW_LOG2;
  localparam int CW = ANIM_PERIOD > 1 ? $clog2(ANIM_PERIOD) : 1;
  logic [PAL_W-1:0]   mem [2**AW];
  logic [TW_LOG2-1:0] sx, col_raw, col;
  logic [TH_LOG2-1:0] sy, row_raw, row;
  logic               mx, my, inb, inb_s1;
  logic [CW-1:0]      cnt;
  logic [9:0]         xo, yo;
  logic [AW-1:0]      addr_s1;
  logic [PAL_W-1:0]   rd;
  // Stage-1 coordinate math: offset, bounds test, scrolled and mirrored tile position
  always_comb begin
    xo      = x + 10'(X_OFFSET);
    yo      = y + 10'(Y_OFFSET);
    inb     = ({1'b0, xo} < 11'(CANVAS_W)) && ({1'b0, yo} < 11'(CANVAS_H));
    col_raw = xo[TW_LOG2-1:0] + sx;
    row_raw = yo[TH_LOG2-1:0] + sy;
    col     = mx ? ~col_raw : col_raw;
    row     = my ? ~row_raw : row_raw;
  end
  assign rd = mem[addr_s1];
  // Shadow registers latch at frame_start; animation frame steps every ANIM_PERIOD frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx        <= '0;
      sy        <= '0;
      mx        <= 1'b0;
      my        <= 1'b0;
      cnt       <= '0;
      cur_frame <= '0;
    end else if (frame_start) begin
      sx <= scroll_x;
      sy <= scroll_y;
      mx <= mirror_x;
      my <= mirror_y;
      if (anim_en) begin
        cnt       <= (cnt == CW'(ANIM_PERIOD - 1)) ? '0 : cnt + 1'b1;
        cur_frame <= (cnt == CW'(ANIM_PERIOD - 1)) ? cur_frame + 1'b1 : cur_frame;
      end
    end
  end
  // Two-stage lookup: register address and bounds, then memory read and transparency test
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_s1      <= '0;
      inb_s1       <= 1'b0;
      paletteIndex <= '0;
      valid        <= 1'b0;
    end else begin
      addr_s1      <= {cur_frame, row, col};
      inb_s1       <= inb;
      paletteIndex <= rd;
      valid        <= inb_s1 && (rd != PAL_W'(TRANSPARENT));
    end
  end
  // Pattern memory write port; a same-edge read sees the old contents
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end
endmodule

// File: tb/tb_tiled_sprite_anim.sv
// tb_tiled_sprite_anim: directed self-checking bench for tiled_sprite_anim
module tb_tiled_sprite_anim;
  logic       clk = 0, rst = 1, frame_start = 0, mirror_x = 0, mirror_y = 0, anim_en = 0, wr_en = 0, valid;
  logic [9:0] x = 0, y = 0;
  logic [2:0] scroll_x = 0, scroll_y = 0;
  logic [7:0] wr_addr = 0;
  logic [3:0] wr_data = 0, paletteIndex;
  logic [1:0] cur_frame;
  int checks = 0, errors = 0;

  tiled_sprite_anim dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .frame_start(frame_start),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .mirror_x(mirror_x), .mirror_y(mirror_y),
    .anim_en(anim_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cur_frame(cur_frame), .paletteIndex(paletteIndex), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pix(input int px, input int py, input int ep, input int ev, input string tag);
    x = 10'(px);
    y = 10'(py);
    tick();
    tick();
    check({tag, "_pi"}, int'(paletteIndex), ep);
    check({tag, "_v"}, int'(valid), ev);
  endtask

  task automatic pulse();
    frame_start = 1;
    tick();
    frame_start = 0;
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1;
    wr_addr = 8'(a);
    wr_data = 4'(d);
    tick();
    wr_en = 0;
  endtask

  initial begin
    tick();
    tick();
    check("rst_pi", int'(paletteIndex), 0);
    check("rst_v", int'(valid), 0);
    check("rst_frame", int'(cur_frame), 0);
    rst = 0;
    for (int f = 0; f < 4; f++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          wr(f * 64 + r * 8 + c, f == 0 ? ((c < 4 && r < 4) ? 8 : 7) : f);
    rst = 1;
    #1;
    rst = 0;
    pulse();
    // pipelined sweep: output after iteration i belongs to x = i-1
    for (int i = 0; i <= 16; i++) begin
      x = 10'(i);
      y = 0;
      tick();
      if (i >= 1) begin
        check($sformatf("sweep_pi_x%0d", i - 1), int'(paletteIndex), ((i - 1) % 8 < 4) ? 8 : 7);
        check($sformatf("sweep_v_x%0d", i - 1), int'(valid), 1);
      end
    end
    pix(159, 0, 7, 1, "edge_x159");
    pix(160, 0, 8, 0, "oob_x160");
    pix(0, 119, 7, 1, "edge_y119");
    pix(0, 120, 8, 0, "oob_y120");
    wr(0, 15);
    pix(0, 0, 15, 0, "transparent");
    wr(0, 8);
    scroll_x = 2;
    pix(2, 0, 8, 1, "scroll_shadow");
    pulse();
    pix(2, 0, 7, 1, "scroll2_x2");
    pix(0, 0, 8, 1, "scroll2_x0");
    scroll_x = 5;
    pix(2, 0, 7, 1, "scroll_hold");
    pulse();
    pix(0, 0, 7, 1, "scroll5_x0");
    pix(3, 0, 8, 1, "scroll5_x3");
    #2;
    rst = 1;
    #1;
    check("async_pi", int'(paletteIndex), 0);
    check("async_v", int'(valid), 0);
    #1;
    rst = 0;
    pix(0, 0, 8, 1, "post_rst_scroll0");
    scroll_x = 0;
    mirror_x = 1;
    pulse();
    pix(0, 0, 7, 1, "mirx_x0");
    pix(7, 0, 8, 1, "mirx_x7");
    mirror_x = 0;
    mirror_y = 1;
    pulse();
    pix(0, 0, 7, 1, "miry_y0");
    pix(0, 7, 8, 1, "miry_y7");
    mirror_y = 0;
    pulse();
    // same-edge write and read of address 0
    x = 0;
    y = 0;
    tick();
    wr(0, 5);
    check("rw_old", int'(paletteIndex), 8);
    tick();
    check("rw_new", int'(paletteIndex), 5);
    wr(0, 8);
    anim_en = 1;
    for (int i = 0; i < 7; i++) pulse();
    check("anim_7", int'(cur_frame), 0);
    pulse();
    check("anim_8", int'(cur_frame), 1);
    pix(0, 0, 1, 1, "anim_f1_pix");
    for (int i = 0; i < 23; i++) pulse();
    check("anim_31", int'(cur_frame), 3);
    pulse();
    check("anim_32_wrap", int'(cur_frame), 0);
    for (int i = 0; i < 8; i++) pulse();
    check("anim_40", int'(cur_frame), 1);
    anim_en = 0;
    for (int i = 0; i < 10; i++) pulse();
    check("anim_hold", int'(cur_frame), 1);
    anim_en = 1;
    for (int i = 0; i < 8; i++) pulse();
    check("anim_resume", int'(cur_frame), 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
